multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle control unit for the reduced RISC-V datapath (register file, ALU operand mux, ALU, data RAM, result mux). Accepts one 32-bit instruction at a time over a valid/ready handshake, decodes it and sequences the datapath controls through FETCH/DECODE/EXEC/MEM/WB states. Owns the program counter, a retired-instruction counter and a sticky illegal-instruction flag. Supports addi, lw, sw, bne.

## Interface
- Data_Width, 32, instruction, PC, immediate and counter width
- Address_Width_RegFile, 5, register address width
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- instr_valid  in  1  fetch side holds a valid instruction
- instr  in  32  instruction word, sampled on handshake
- instr_ready  out  1  controller accepts an instruction this cycle
- eq  in  1  ALU zero flag (op1 == op2 under subtract)
- pc  out  32  address of the instruction in flight / next to fetch
- rs1, rs2, rd  out  5  register addresses from latched instruction
- ImmOp  out  32  sign-extended immediate
- regFileWen, ALUSrc, ALU_ctrl, MemWrite, ResultSrc  out  1 each  datapath controls
- retire  out  1  one-cycle pulse in last cycle of each instruction
- retired_count  out  32  instructions retired since reset
- illegal  out  1  sticky; set on any unsupported encoding

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB. Reset state IDLE; IDLE -> FETCH unconditionally.
- FETCH: instr_ready=1; on instr_valid&&instr_ready latch instr into IR, -> DECODE. Otherwise stay.
- DECODE: rs1=IR[19:15], rs2=IR[24:20], rd=IR[11:7], ImmOp valid; all held until the instruction retires. -> EXEC.
- Supported: addi (opcode 0010011, f3 000), lw (0000011, 010), sw (0100011, 010), bne (1100011, 001). Anything else illegal.
- Immediates: I = sext(IR[31:20]); S = sext({IR[31:25],IR[11:7]}); B = sext({IR[31],IR[7],IR[30:25],IR[11:8],1'b0}).
- ALU_ctrl: 0 = add (addi, lw, sw), 1 = sub (bne). ALUSrc=1 for addi/lw/sw, 0 for bne. ResultSrc=1 for lw only.
- EXEC: addi -> WB; lw/sw -> MEM; bne samples eq, retires, -> FETCH; illegal sets flag, retires, -> FETCH.
- MEM: sw asserts MemWrite for exactly this cycle, retires, -> FETCH; lw -> WB (no write).
- WB: regFileWen=1 for exactly this cycle, retires, -> FETCH.
- regFileWen and MemWrite are 0 in every other state; never both high.
- PC update at end of retiring cycle: bne with eq=0 -> pc+ImmOp; else pc+4. Arithmetic modulo 2^32. Illegal instructions advance by 4.
- retired_count increments on retire, wraps 0xFFFFFFFF -> 0. Illegal instructions count.
- illegal cleared only by reset.

## Timing
- Cycles from handshake edge to retire: addi 3 (DECODE, EXEC, WB), lw 4, sw 3, bne 2, illegal 2. Next FETCH follows retire immediately.
- instr_ready is a state decode, 0 during reset and IDLE; first ready in second cycle after rst_n release.
- instr_valid/instr ignored outside FETCH; no skid buffer.
- Reset values: pc=0, retired_count=0, illegal=0, IR=0, all controls and retire=0, instr_ready=0.
- Reset asserted mid-instruction aborts it: no write issued after assertion, pc and counters return to 0.
- eq sampled only in EXEC of bne; value elsewhere ignored.

## Structure
- Shared package riscv_ctrl_pkg: state enum, opcode and funct3 constants, ALU_ctrl encodings (ALU_ADD, ALU_SUB).
- Sub-module imm_gen: combinational IR -> ImmOp by format (I/S/B).
- FSM, IR, pc, counter, illegal flag in multicycle_ctrl top.

## Test plan
- addi x5,x0,7 (0x00700293) -> instr_ready low 3 cycles; regFileWen high only in WB with rd=5, ImmOp=7, ALUSrc=1, ALU_ctrl=0; pc 0 -> 4; retired_count=1.
- sw x5,8(x0) then lw x6,8(x0) -> MemWrite one cycle, ImmOp=8; lw takes 4 cycles, ResultSrc=1 and regFileWen in WB, rd=6; pc=8 after both.
- bne x1,x2,-8 at pc=0x10: eq=0 -> pc=0x08; eq=1 -> pc=0x14; no writes, ALU_ctrl=1, ALUSrc=0.
- instr=0xFFFFFFFF -> illegal=1 sticky, pc+4, no regFileWen/MemWrite, retired_count increments.
- instr_valid held low 10 cycles in FETCH -> state, pc, outputs unchanged; then accepted on first valid cycle.
- rst_n low during lw MEM state -> regFileWen never asserts, pc=0, counters 0; ready reappears second cycle after release.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RISC-V control unit.
package riscv_ctrl_pkg;

    // Controller sequencing states
    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb
    } state_e;

    // Decoded instruction class; ClsIllegal covers every unsupported encoding
    typedef enum logic [2:0] {
        ClsIllegal,
        ClsAddi,
        ClsLw,
        ClsSw,
        ClsBne
    } instr_cls_e;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADDI = 3'b000;
    localparam logic [2:0] F3_LW   = 3'b010;
    localparam logic [2:0] F3_SW   = 3'b010;
    localparam logic [2:0] F3_BNE  = 3'b001;

    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_SUB = 1'b1;

    // Classify an instruction word by opcode and funct3
    function automatic instr_cls_e decode_class(input logic [31:0] ir);
        instr_cls_e cls;
        cls = ClsIllegal;
        unique case (ir[6:0])
            OPC_OP_IMM: if (ir[14:12] == F3_ADDI) cls = ClsAddi;
            OPC_LOAD:   if (ir[14:12] == F3_LW)   cls = ClsLw;
            OPC_STORE:  if (ir[14:12] == F3_SW)   cls = ClsSw;
            OPC_BRANCH: if (ir[14:12] == F3_BNE)  cls = ClsBne;
            default:    cls = ClsIllegal;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: sign-extends the I/S/B-format immediate of the latched instruction.
module imm_gen
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned Data_Width = 32
) (
    input  logic [31:0]           ir,
    output logic [Data_Width-1:0] imm
);

    // Select the immediate layout from the opcode; I-format is the fallback
    always_comb begin
        imm = '0;
        unique case (ir[6:0])
            OPC_STORE:  imm = {{(Data_Width-12){ir[31]}}, ir[31:25], ir[11:7]};
            OPC_BRANCH: imm = {{(Data_Width-13){ir[31]}}, ir[31], ir[7], ir[30:25],
                               ir[11:8], 1'b0};
            default:    imm = {{(Data_Width-12){ir[31]}}, ir[31:20]};
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control unit: fetch handshake, decode, and datapath sequencing for
// addi/lw/sw/bne. Owns the PC, retired-instruction counter and sticky illegal flag.
module multicycle_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned Data_Width            = 32,
    parameter int unsigned Address_Width_RegFile = 5
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             instr_valid,
    input  logic [31:0]                      instr,
    output logic                             instr_ready,
    input  logic                             eq,
    output logic [Data_Width-1:0]            pc,
    output logic [Address_Width_RegFile-1:0] rs1,
    output logic [Address_Width_RegFile-1:0] rs2,
    output logic [Address_Width_RegFile-1:0] rd,
    output logic [Data_Width-1:0]            ImmOp,
    output logic                             regFileWen,
    output logic                             ALUSrc,
    output logic                             ALU_ctrl,
    output logic                             MemWrite,
    output logic                             ResultSrc,
    output logic                             retire,
    output logic [Data_Width-1:0]            retired_count,
    output logic                             illegal
);

    state_e                state_q, state_d;
    logic [31:0]           ir_q;
    logic [Data_Width-1:0] pc_q;
    logic [Data_Width-1:0] count_q;
    logic                  illegal_q;
    instr_cls_e            cls;
    logic                  take_branch;
    logic                  set_illegal;

    assign cls = decode_class(ir_q);

    imm_gen #(
        .Data_Width(Data_Width)
    ) u_imm_gen (
        .ir  (ir_q),
        .imm (ImmOp)
    );

    // Register fields come straight from IR, so they hold until the next handshake
    assign rs1 = Address_Width_RegFile'(ir_q[19:15]);
    assign rs2 = Address_Width_RegFile'(ir_q[24:20]);
    assign rd  = Address_Width_RegFile'(ir_q[11:7]);

    // Static datapath controls decoded from the latched instruction
    always_comb begin
        ALUSrc    = (cls == ClsAddi) || (cls == ClsLw) || (cls == ClsSw);
        ALU_ctrl  = (cls == ClsBne) ? ALU_SUB : ALU_ADD;
        ResultSrc = (cls == ClsLw);
    end

    // Next-state and per-state strobes
    always_comb begin
        state_d     = state_q;
        instr_ready = 1'b0;
        regFileWen  = 1'b0;
        MemWrite    = 1'b0;
        retire      = 1'b0;
        take_branch = 1'b0;
        set_illegal = 1'b0;
        unique case (state_q)
            StIdle: state_d = StFetch;
            StFetch: begin
                instr_ready = 1'b1;
                if (instr_valid) state_d = StDecode;
            end
            StDecode: state_d = StExec;
            StExec: begin
                case (cls)
                    ClsAddi:       state_d = StWb;
                    ClsLw, ClsSw:  state_d = StMem;
                    ClsBne: begin
                        retire      = 1'b1;
                        take_branch = !eq;
                        state_d     = StFetch;
                    end
                    default: begin
                        retire      = 1'b1;
                        set_illegal = 1'b1;
                        state_d     = StFetch;
                    end
                endcase
            end
            StMem: begin
                if (cls == ClsSw) begin
                    MemWrite = 1'b1;
                    retire   = 1'b1;
                    state_d  = StFetch;
                end else begin
                    state_d = StWb;
                end
            end
            StWb: begin
                regFileWen = 1'b1;
                retire     = 1'b1;
                state_d    = StFetch;
            end
            default: state_d = StIdle;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // Instruction register, loaded only on the fetch handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                           ir_q <= '0;
        else if (instr_ready && instr_valid) ir_q <= instr;
    end

    // PC, retire counter and sticky illegal flag update on the retiring cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= '0;
            count_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            if (retire) begin
                pc_q    <= take_branch ? pc_q + ImmOp : pc_q + Data_Width'(4);
                count_q <= count_q + Data_Width'(1);
            end
            if (set_illegal) illegal_q <= 1'b1;
        end
    end

    assign pc            = pc_q;
    assign retired_count = count_q;
    assign illegal       = illegal_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: table-driven instruction vectors plus
// hand-written reset, stall and mid-instruction-reset sequences.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic        eq;
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] ImmOp;
    logic        regFileWen, ALUSrc, ALU_ctrl, MemWrite, ResultSrc;
    logic        retire;
    logic [31:0] retired_count;
    logic        illegal;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(
        .Data_Width            (32),
        .Address_Width_RegFile (5)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_ready   (instr_ready),
        .eq            (eq),
        .pc            (pc),
        .rs1           (rs1),
        .rs2           (rs2),
        .rd            (rd),
        .ImmOp         (ImmOp),
        .regFileWen    (regFileWen),
        .ALUSrc        (ALUSrc),
        .ALU_ctrl      (ALU_ctrl),
        .MemWrite      (MemWrite),
        .ResultSrc     (ResultSrc),
        .retire        (retire),
        .retired_count (retired_count),
        .illegal       (illegal)
    );

    typedef struct {
        logic [31:0] instr;
        logic        eq;
        int          cycles;
        logic [31:0] pc_after;
        int          wen_n;
        int          mw_n;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        chk_ctl;
        logic [31:0] imm;
        logic        alusrc;
        logic        aluctrl;
        logic        ressrc;
        logic        illegal;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    initial begin
        vec_t        tbl [10];
        int          waited, cyc, wen_n, mw_n, ovl, rdy_n, bad;
        logic        got_ret, wen_ret;
        logic [4:0]  s_rs1, s_rs2, s_rd;
        logic [31:0] s_imm;
        logic        s_src, s_alu, s_res;

        //            instr         eq  cyc pc_after wen mw rs1 rs2 rd ctl imm          src alu res ill
        tbl[0] = '{32'h00700293, 1'b0, 3, 32'h04, 1, 0, 5'd0, 5'd7, 5'd5, 1'b1, 32'h7,
                   1'b1, 1'b0, 1'b0, 1'b0};                        // addi x5,x0,7
        tbl[1] = '{32'h00502423, 1'b0, 3, 32'h08, 0, 1, 5'd0, 5'd5, 5'd8, 1'b1, 32'h8,
                   1'b1, 1'b0, 1'b0, 1'b0};                        // sw x5,8(x0)
        tbl[2] = '{32'h00802303, 1'b0, 4, 32'h0C, 1, 0, 5'd0, 5'd8, 5'd6, 1'b1, 32'h8,
                   1'b1, 1'b0, 1'b1, 1'b0};                        // lw x6,8(x0)
        tbl[3] = '{32'h00100093, 1'b0, 3, 32'h10, 1, 0, 5'd0, 5'd1, 5'd1, 1'b1, 32'h1,
                   1'b1, 1'b0, 1'b0, 1'b0};                        // addi x1,x0,1
        tbl[4] = '{32'hFE209CE3, 1'b0, 2, 32'h08, 0, 0, 5'd1, 5'd2, 5'd25, 1'b1,
                   32'hFFFFFFF8, 1'b0, 1'b1, 1'b0, 1'b0};          // bne taken
        tbl[5] = '{32'h00100093, 1'b1, 3, 32'h0C, 1, 0, 5'd0, 5'd1, 5'd1, 1'b1, 32'h1,
                   1'b1, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{32'h00100093, 1'b0, 3, 32'h10, 1, 0, 5'd0, 5'd1, 5'd1, 1'b1, 32'h1,
                   1'b1, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{32'hFE209CE3, 1'b1, 2, 32'h14, 0, 0, 5'd1, 5'd2, 5'd25, 1'b1,
                   32'hFFFFFFF8, 1'b0, 1'b1, 1'b0, 1'b0};          // bne not taken
        tbl[8] = '{32'hFFFFFFFF, 1'b0, 2, 32'h18, 0, 0, 5'd31, 5'd31, 5'd31, 1'b0, 32'h0,
                   1'b0, 1'b0, 1'b0, 1'b1};                        // illegal
        tbl[9] = '{32'h00700293, 1'b0, 3, 32'h1C, 1, 0, 5'd0, 5'd7, 5'd5, 1'b1, 32'h7,
                   1'b1, 1'b0, 1'b0, 1'b1};                        // illegal stays set

        // Reset state
        rst_n = 1'b0; instr_valid = 1'b0; instr = '0; eq = 1'b0;
        repeat (3) step();
        chk("rst_pc", pc, 32'h0);
        chk("rst_count", retired_count, 32'h0);
        chk("rst_illegal", illegal, 1'b0);
        chk("rst_ready", instr_ready, 1'b0);
        chk("rst_strobes", {regFileWen, MemWrite, retire}, 3'b000);
        chk("rst_ctl", {ALUSrc, ALU_ctrl, ResultSrc}, 3'b000);
        chk("rst_rd_imm", {rd, ImmOp[26:0]}, 32'h0);
        rst_n = 1'b1;
        chk("rel_ready_first", instr_ready, 1'b0);
        step();
        chk("rel_ready_second", instr_ready, 1'b1);

        // Stall in FETCH with valid low and junk on instr
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            instr = $urandom;
            eq    = 1'(k);
            step();
            if (instr_ready !== 1'b1 || pc !== 32'h0 || regFileWen || MemWrite || retire
                || retired_count !== 32'h0)
                bad++;
        end
        chk("stall_unchanged", bad, 0);

        // Table-driven instruction vectors
        for (int i = 0; i < 10; i++) begin
            waited = 0;
            while (!instr_ready && waited < 20) begin
                step();
                waited++;
            end
            chk($sformatf("v%0d_accept_wait", i), waited, 0);
            instr = tbl[i].instr; instr_valid = 1'b1; eq = ~tbl[i].eq;
            step();
            instr_valid = 1'b0; instr = $urandom;
            cyc = 1; wen_n = 0; mw_n = 0; ovl = 0; rdy_n = 0;
            got_ret = 1'b0; wen_ret = 1'b0;
            s_rs1 = '0; s_rs2 = '0; s_rd = '0; s_imm = '0; s_src = 0; s_alu = 0; s_res = 0;
            while (cyc <= 8) begin
                if (cyc >= 2) eq = tbl[i].eq;
                #1;
                wen_n += int'(regFileWen);
                mw_n  += int'(MemWrite);
                if (regFileWen && MemWrite) ovl++;
                rdy_n += int'(instr_ready);
                if (retire) begin
                    got_ret = 1'b1; wen_ret = regFileWen;
                    s_rs1 = rs1; s_rs2 = rs2; s_rd = rd; s_imm = ImmOp;
                    s_src = ALUSrc; s_alu = ALU_ctrl; s_res = ResultSrc;
                    break;
                end
                step();
                cyc++;
            end
            if (!got_ret) cyc = 99;
            chk($sformatf("v%0d_cycles", i), cyc, tbl[i].cycles);
            chk($sformatf("v%0d_wen_count", i), wen_n, tbl[i].wen_n);
            chk($sformatf("v%0d_wen_at_retire", i), wen_ret, tbl[i].wen_n > 0);
            chk($sformatf("v%0d_memwrite_count", i), mw_n, tbl[i].mw_n);
            chk($sformatf("v%0d_overlap", i), ovl, 0);
            chk($sformatf("v%0d_ready_in_flight", i), rdy_n, 0);
            chk($sformatf("v%0d_regs", i), {s_rs1, s_rs2, s_rd},
                {tbl[i].rs1, tbl[i].rs2, tbl[i].rd});
            if (tbl[i].chk_ctl) begin
                chk($sformatf("v%0d_imm", i), s_imm, tbl[i].imm);
                chk($sformatf("v%0d_ctl", i), {s_src, s_alu, s_res},
                    {tbl[i].alusrc, tbl[i].aluctrl, tbl[i].ressrc});
            end
            step();
            chk($sformatf("v%0d_pc", i), pc, tbl[i].pc_after);
            chk($sformatf("v%0d_count", i), retired_count, i + 1);
            chk($sformatf("v%0d_illegal", i), illegal, tbl[i].illegal);
            chk($sformatf("v%0d_ready_next", i), instr_ready, 1'b1);
        end

        // Reset asserted while an lw sits in MEM
        waited = 0;
        while (!instr_ready && waited < 20) begin
            step();
            waited++;
        end
        chk("mid_accept_wait", waited, 0);
        instr = 32'h00802303; instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        step();
        step();
        chk("mid_in_mem", {regFileWen, MemWrite, retire}, 3'b000);
        rst_n = 1'b0;
        #1;
        chk("mid_pc", pc, 32'h0);
        chk("mid_count", retired_count, 32'h0);
        chk("mid_illegal", illegal, 1'b0);
        chk("mid_ready", instr_ready, 1'b0);
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (regFileWen || MemWrite || retire) bad++;
        end
        chk("mid_no_write", bad, 0);
        rst_n = 1'b1;
        chk("mid_rel_ready_first", instr_ready, 1'b0);
        step();
        chk("mid_rel_ready_second", instr_ready, 1'b1);
        chk("mid_rel_pc", pc, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
